// File: rtl/router_oport_rx.sv
// Router output-port receiver: deserializes one port's LSB-first serial stream
// into bytes, tags the last byte of each packet, and buffers them in an FWFT FIFO.
module router_oport_rx #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frameo_n,
  input  logic             valido_n,
  input  logic             dout,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             err_framing,
  output logic             err_overflow,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_inc, byte_cnt_nxt;
  logic             active, bit_en, complete, end_cyc;

  logic [8:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, push_ok;

  // Handshake: the head byte transfers on any posedge where byte_valid && byte_ready.
  // An IDLE cycle with frameo_n low is already the first ACTIVE cycle.
  always_comb begin
    state_nxt    = state;
    active       = (state == ACTIVE) || !frameo_n;
    bit_en       = active && !valido_n;
    complete     = bit_en && (bit_cnt == 3'd7);
    end_cyc      = active && frameo_n;
    byte_cnt_inc = (byte_cnt == {LEN_W{1'b1}}) ? byte_cnt : byte_cnt + 1'b1;
    byte_cnt_nxt = complete ? byte_cnt_inc : byte_cnt;
    if (active) state_nxt = frameo_n ? IDLE : ACTIVE;
  end

  assign busy       = (state == ACTIVE);
  assign byte_valid = (count != '0);
  assign full       = (count == (AW + 1)'(DEPTH));
  assign pop        = byte_valid && byte_ready;
  assign push_ok    = complete && (!full || pop);
  assign byte_data  = byte_valid ? mem[rd_ptr][7:0] : 8'd0;
  assign byte_last  = byte_valid ? mem[rd_ptr][8] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_q      <= '0;
      byte_cnt     <= '0;
      pkt_done     <= 1'b0;
      pkt_len      <= '0;
      err_framing  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      pkt_done     <= end_cyc;
      err_framing  <= end_cyc && !complete;
      pkt_len      <= end_cyc ? byte_cnt_nxt : '0;
      err_overflow <= complete && full && !pop;
      if (end_cyc) begin
        // Any partial byte left at the end of a packet is discarded.
        bit_cnt  <= '0;
        shift_q  <= '0;
        byte_cnt <= '0;
      end else begin
        if (bit_en) begin
          shift_q[bit_cnt] <= dout;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        byte_cnt <= byte_cnt_nxt;
      end
    end
  end

  // Storage has no reset; the head is gated by byte_valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {frameo_n, dout, shift_q[6:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/router_oport_rx.md
Name: router_oport_rx

Overview:
Single-port receiver for the router output side. It samples one port's serial output stream (frameo_n, valido_n, dout), deserializes bits LSB-first into bytes, and marks the final byte of each packet. Bytes are buffered in a first-word-fall-through FIFO with a valid/ready drain interface. Framing and overflow errors are flagged. One instance per router output port, used in the bench harness and by downstream packet consumers.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, 2..256
LEN_W, 8, width of the packet byte counter pkt_len

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
frameo_n  input  1  router output frame, active low; low for the packet duration, high on the last-bit cycle
valido_n  input  1  router output bit valid, active low
dout  input  1  router output serial data bit
byte_data  output  8  head-of-FIFO byte
byte_last  output  1  head byte is the last byte of its packet
byte_valid  output  1  FIFO not empty
byte_ready  input  1  consumer accepts the head byte when byte_valid=1
pkt_done  output  1  one-cycle pulse: packet ended (clean or error)
pkt_len  output  LEN_W  completed bytes in the ended packet; valid while pkt_done=1; saturates at all-ones
err_framing  output  1  one-cycle pulse, concurrent with pkt_done, when the packet ended misaligned
err_overflow  output  1  one-cycle pulse when a completed byte is dropped because the FIFO is full
busy  output  1  1 while in state ACTIVE

Behaviour:
- Reset (reset=1 at posedge): state IDLE, bit_cnt=0, shift register=0, FIFO empty, byte_cnt=0. All outputs 0: byte_valid, byte_data, byte_last, pkt_done, pkt_len, err_framing, err_overflow, busy. Reset overrides any in-flight packet or FIFO contents, and partial bits are discarded. Inputs are ignored during reset.
- States: IDLE, ACTIVE.
- IDLE:
  - frameo_n=0 -> ACTIVE. The current cycle is processed as an ACTIVE cycle, so a bit with valido_n=0 is captured.
  - frameo_n=1 -> stay in IDLE; valido_n and dout are ignored.
- ACTIVE, per cycle:
  - valido_n=0: dout goes into bit position bit_cnt; bit_cnt increments mod 8.
  - valido_n=1: gap cycle; no shift and no count change.
  - Byte complete when valido_n=0 and bit_cnt=7. The byte {last, data} is pushed, where last=frameo_n of the same cycle. byte_cnt increments and saturates.
  - frameo_n=1 is the end cycle. It moves the block to IDLE after processing.
    - Clean end requires valido_n=0 and bit_cnt=7 on that cycle.
    - Any other end cycle (gap cycle, or bit_cnt≠7) raises err_framing. Partial bits are discarded. The last byte already pushed keeps last=0.
- End handling:
  - The cycle after the end cycle: pkt_done=1 and pkt_len=byte_cnt (includes bytes dropped by overflow). err_framing=1 on the same cycle if applicable.
  - byte_cnt clears.
  - A new packet may start on that same cycle: frameo_n=0 one cycle after the end cycle gives back-to-back operation with no lost bit.
- FIFO:
  - Push happens at the posedge of the completing cycle. byte_valid rises the next cycle: one-cycle latency from last bit to visible byte.
  - Head is combinationally presented: byte_data/byte_last come from the head entry when byte_valid=1, else 0.
  - Pop when byte_valid && byte_ready.
  - Simultaneous push and pop when full: push accepted, count unchanged.
  - Push when full without pop: byte dropped, err_overflow pulses the next cycle, byte_cnt still increments.
  - Pointers wrap mod DEPTH.
  - Pop when empty is ignored.

Test Plan:
- Single byte 0xA5 sent as bits 1,0,1,0,0,1,0,1 with valido_n=0 for 8 cycles and frameo_n=1 on the 8th -> next cycle: byte_valid=1, byte_data=0xA5, byte_last=1, pkt_done=1, pkt_len=1, err_framing=0.
- Two bytes 0x3C,0xF0 with two valido_n=1 gap cycles after bit 3, byte_ready=1 -> pops 0x3C (last=0) then 0xF0 (last=1); gaps do not shift data; pkt_len=2.
- 12-bit packet, frameo_n=1 on bit 12 -> one byte pushed with last=0; err_framing=1 and pkt_done=1 with pkt_len=1; state IDLE; partial nibble absent from FIFO.
- DEPTH=4, byte_ready=0, 6-byte packet 0x01..0x06 -> FIFO holds 0x01..0x04; err_overflow pulses twice; pkt_len=6; draining yields 4 bytes, none with last=1.
- Back-to-back: packet 0x11 end cycle, then frameo_n=0 next cycle with packet 0x22 -> both bytes delivered with last=1; two pkt_done pulses, each pkt_len=1.
- reset=1 at bit 5 of a byte with 3 bytes buffered -> next cycle: byte_valid=0, busy=0, no pkt_done; a subsequent clean 0x7E packet is received correctly.
